// File: rtl/uart_pkg.sv
// Shared constants for the parameterised UART transmitter: FSM encoding and parity modes.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Mode 2'b11 is treated as no parity.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit character FIFO with occupancy level, almost-full threshold and overflow pulse.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned FIFO_AW   = 4
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 wr_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  input  logic                 pop_i,
  input  logic [FIFO_AW:0]     thresh_i,
  output logic [DATA_BITS-1:0] rdata_o,
  output logic [FIFO_AW:0]     level_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic                 overflow_o
);

  localparam int unsigned        Depth    = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   DepthLvl = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   LvlOne   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PtrOne   = FIFO_AW'(1);

  logic [DATA_BITS-1:0] mem_q [Depth];
  logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]     level_q, level_d;
  logic [FIFO_AW:0]     thresh_eff;
  logic                 overflow_q;
  logic                 push, pop;

  assign pop  = pop_i && (level_q != '0);
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign push = wr_i && ((level_q != DepthLvl) || pop);

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LvlOne;
    end else if (!push && pop) begin
      level_d = level_q - LvlOne;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      level_q    <= level_d;
      overflow_q <= wr_i && !push;
    end
  end

  always_ff @(posedge clock_i) begin
    if (push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Out-of-range thresholds collapse to the true depth.
  assign thresh_eff = ((thresh_i == '0) || (thresh_i > DepthLvl)) ? DepthLvl : thresh_i;

  assign rdata_o    = mem_q[rd_ptr_q];
  assign level_o    = level_q;
  assign empty_o    = (level_q == '0);
  assign full_o     = (level_q >= thresh_eff);
  assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: FIFO-fed framer with latched per-frame baud/parity/stop config.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned FIFO_AW   = 4,
  parameter int unsigned DIV_W     = 16
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 data_write_i,
  input  logic [FIFO_AW:0]     data_buffer_full_tresh_i,
  input  logic [DIV_W-1:0]     baud_div_i,
  input  logic [1:0]           parity_mode_i,
  input  logic                 stop_bits_i,
  input  logic                 tx_enable_i,
  output logic                 data_buffer_full_o,
  output logic                 data_buffer_empty_o,
  output logic [FIFO_AW:0]     data_buffer_level_o,
  output logic                 overflow_o,
  output logic                 busy_o,
  output logic                 uart_tx_o
);

  localparam logic [DIV_W-1:0] DivOne  = DIV_W'(1);
  localparam logic [2:0]       LastBit = 3'(DATA_BITS - 1);

  logic [2:0]           state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 par_en_q, par_en_d;
  logic                 stop2_q, stop2_d;
  logic                 stop_n_q, stop_n_d;

  logic                 fifo_pop;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 bit_end;
  logic                 start_ok;
  logic                 load;

  uart_tx_fifo #(
    .DATA_BITS (DATA_BITS),
    .FIFO_AW   (FIFO_AW)
  ) u_fifo (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .wr_i       (data_write_i),
    .wdata_i    (data_i),
    .pop_i      (fifo_pop),
    .thresh_i   (data_buffer_full_tresh_i),
    .rdata_o    (fifo_rdata),
    .level_o    (data_buffer_level_o),
    .empty_o    (fifo_empty),
    .full_o     (data_buffer_full_o),
    .overflow_o (overflow_o)
  );

  assign bit_end  = (cnt_q == div_q);
  assign start_ok = tx_enable_i && !fifo_empty;

  always_comb begin
    state_d   = state_q;
    cnt_d     = bit_end ? '0 : cnt_q + DivOne;
    div_d     = div_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
    stop2_d   = stop2_q;
    stop_n_d  = stop_n_q;
    load      = 1'b0;
    fifo_pop  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        load  = start_ok;
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == LastBit) begin
            state_d  = par_en_q ? ST_PARITY : ST_STOP;
            stop_n_d = 1'b0;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d  = ST_STOP;
          stop_n_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_n_q) begin
            stop_n_d = 1'b1;
          end else if (start_ok) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pop the head and freeze the line configuration for the whole frame.
    if (load) begin
      fifo_pop  = 1'b1;
      state_d   = ST_START;
      cnt_d     = '0;
      div_d     = baud_div_i;
      shift_d   = fifo_rdata;
      par_en_d  = parity_enabled(parity_mode_i);
      par_bit_d = (^fifo_rdata) ^ (parity_mode_i == PAR_ODD);
      stop2_d   = stop_bits_i;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      stop_n_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
      stop2_q   <= stop2_d;
      stop_n_q  <= stop_n_d;
    end
  end

  always_comb begin
    uart_tx_o = 1'b1;
    case (state_q)
      ST_START:  uart_tx_o = 1'b0;
      ST_DATA:   uart_tx_o = shift_q[0];
      ST_PARITY: uart_tx_o = par_bit_q;
      default:   uart_tx_o = 1'b1;
    endcase
  end

  assign busy_o              = (state_q != ST_IDLE);
  assign data_buffer_empty_o = fifo_empty;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param with a 4-deep FIFO; expected line patterns are hand-built frames.
module tb_uart_tx_param;

  logic        clk;
  logic        rst;
  logic [7:0]  data;
  logic        wr;
  logic [2:0]  thr;
  logic [15:0] div;
  logic [1:0]  par;
  logic        stop2;
  logic        tx_en;
  logic        full, empty, overflow, busy, tx;
  logic [2:0]  level;

  int vectors;
  int miscompares;

  uart_tx_param #(
    .DATA_BITS (8),
    .FIFO_AW   (2),
    .DIV_W     (16)
  ) dut (
    .clock_i                  (clk),
    .reset_i                  (rst),
    .data_i                   (data),
    .data_write_i             (wr),
    .data_buffer_full_tresh_i (thr),
    .baud_div_i               (div),
    .parity_mode_i            (par),
    .stop_bits_i              (stop2),
    .tx_enable_i              (tx_en),
    .data_buffer_full_o       (full),
    .data_buffer_empty_o      (empty),
    .data_buffer_level_o      (level),
    .overflow_o               (overflow),
    .busy_o                   (busy),
    .uart_tx_o                (tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_char(input logic [7:0] d);
    data = d;
    wr   = 1'b1;
    tick();
    wr   = 1'b0;
  endtask

  // pat[0] is the first bit on the line (start bit); entered on the first START cycle.
  task automatic run_frame(input string tag, input logic [11:0] pat, input int nbits,
                           input int bclk);
    for (int c = 0; c < nbits * bclk; c++) begin
      check(tag, {31'd0, tx}, {31'd0, pat[c / bclk]});
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      tick();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    data  = 8'h00;
    wr    = 1'b0;
    thr   = 3'd0;
    div   = 16'd3;
    par   = 2'b00;
    stop2 = 1'b0;
    tx_en = 1'b1;
    tick();
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // 8N1 div 3, 0xA5: 40 busy clocks, then idle.
    write_char(8'hA5);
    check("a5_pre_tx", {31'd0, tx}, 32'd1);
    check("a5_pre_busy", {31'd0, busy}, 32'd0);
    tick();
    run_frame("a5", 12'b00_1_10100101_0, 10, 4);
    check("a5_end_busy", {31'd0, busy}, 32'd0);
    check("a5_end_tx", {31'd0, tx}, 32'd1);

    // Even parity 0x07 -> parity 1; tx_enable dropped mid-frame must not cut it short.
    par = 2'b01;
    write_char(8'h07);
    tick();
    tx_en = 1'b0;
    run_frame("even07", 12'b0_1_1_00000111_0, 11, 4);
    check("even07_end", {31'd0, busy}, 32'd0);
    tx_en = 1'b1;

    // Odd parity 0x07 -> parity 0, two stop bits.
    par   = 2'b10;
    stop2 = 1'b1;
    write_char(8'h07);
    tick();
    run_frame("odd07_2s", 12'b1_1_0_00000111_0, 12, 4);
    check("odd07_end", {31'd0, busy}, 32'd0);

    // Config change mid-frame: first frame keeps div 3 / none, next uses div 1 / even.
    par   = 2'b00;
    stop2 = 1'b0;
    tx_en = 1'b0;
    write_char(8'h3C);
    write_char(8'h01);
    tx_en = 1'b1;
    tick();
    div = 16'd1;
    par = 2'b01;
    run_frame("cfg_old", 12'b00_1_00111100_0, 10, 4);
    run_frame("cfg_new", 12'b0_1_1_00000001_0, 11, 2);
    check("cfg_end_busy", {31'd0, busy}, 32'd0);
    check("cfg_end_tx", {31'd0, tx}, 32'd1);

    // Threshold and overflow with transmission disabled.
    div   = 16'd3;
    par   = 2'b00;
    tx_en = 1'b0;
    thr   = 3'd2;
    write_char(8'h11);
    check("thr2_lvl1", {29'd0, level}, 32'd1);
    check("thr2_full1", {31'd0, full}, 32'd0);
    write_char(8'h22);
    check("thr2_lvl2", {29'd0, level}, 32'd2);
    check("thr2_full2", {31'd0, full}, 32'd1);
    thr = 3'd0;
    #1;
    check("thr0_full2", {31'd0, full}, 32'd0);
    write_char(8'h33);
    check("thr0_full3", {31'd0, full}, 32'd0);
    write_char(8'h44);
    check("lvl4", {29'd0, level}, 32'd4);
    check("thr0_full4", {31'd0, full}, 32'd1);
    check("ovf_before", {31'd0, overflow}, 32'd0);
    write_char(8'h55);
    check("ovf_pulse", {31'd0, overflow}, 32'd1);
    check("ovf_lvl", {29'd0, level}, 32'd4);
    tick();
    check("ovf_clear", {31'd0, overflow}, 32'd0);
    check("ovf_lvl2", {29'd0, level}, 32'd4);

    // Drain four frames back-to-back; 0x55 was dropped.
    tx_en = 1'b1;
    tick();
    check("drain_lvl3", {29'd0, level}, 32'd3);
    run_frame("f11", 12'b00_1_00010001_0, 10, 4);
    run_frame("f22", 12'b00_1_00100010_0, 10, 4);
    run_frame("f33", 12'b00_1_00110011_0, 10, 4);
    run_frame("f44", 12'b00_1_01000100_0, 10, 4);
    check("drain_busy", {31'd0, busy}, 32'd0);
    check("drain_empty", {31'd0, empty}, 32'd1);
    check("drain_lvl0", {29'd0, level}, 32'd0);

    // Asynchronous reset in the middle of a data bit.
    tx_en = 1'b0;
    write_char(8'h00);
    write_char(8'h50);
    tx_en = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) tick();
    check("mid_tx", {31'd0, tx}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd1);
    check("mid_lvl", {29'd0, level}, 32'd1);
    rst = 1'b1;
    #1;
    check("arst_tx", {31'd0, tx}, 32'd1);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_lvl", {29'd0, level}, 32'd0);
    check("arst_empty", {31'd0, empty}, 32'd1);
    tick();
    rst = 1'b0;
    tick();
    check("post_lvl", {29'd0, level}, 32'd0);
    check("post_busy", {31'd0, busy}, 32'd0);
    check("post_tx", {31'd0, tx}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
